adder_tree_feeder: RTL
======================

# adder_tree_feeder

Stream-side front end for the pipelined 2:1 adder tree. It accepts a valid/ready word stream, packs up to NUM words into a parallel vector and issues that vector to the tree. It tracks the tree's fixed latency and then presents each frame's sum on a registered valid-qualified output, together with the count of real words in the frame. Frames that `s_last` closes early are zero-padded to NUM lanes.

## Interface
- `SIZE`, 10: word width, and also the sum width (sum wraps modulo 2^SIZE).
- `NUM`, 1024: tree fan-in, i.e. lanes per frame; NUM ≥ 1.
- `TREE_LAT` (localparam): 0 if NUM=1, otherwise ceil(log2 NUM). This is the tree's register depth.
- `CW` (localparam): $clog2(NUM+1), the width of the word count.

Ports:
- `clk`  in  1  the single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word ready.
- `s_data`  in  SIZE  input word.
- `s_last`  in  1  marks the final word of a frame.
- `tree_din`  out  SIZE × [0:NUM-1]  registered vector driven to the tree.
- `tree_dout`  in  SIZE  tree sum output.
- `m_valid`  out  1  one-cycle pulse: the frame sum is valid.
- `m_data`  out  SIZE  frame sum.
- `m_count`  out  CW  number of real (non-pad) words in the frame, 1..NUM.

## Operation
- A beat is accepted on an edge where `s_valid && s_ready` holds.
- `s_ready` is 1 whenever `rst` is 0. The tree is fully pipelined, so the block never backpressures.
- Fill buffer: NUM×SIZE registers plus a lane counter `fill` (0..NUM-1).
  - An accepted beat writes `s_data` into lane `fill`.
- FSM:
  - States: IDLE (`fill`=0) and FILL (`fill`>0).
  - Transitions:
    - IDLE → FILL on an accepted beat that does not close the frame.
    - FILL → IDLE on the closing beat.
  - A beat closes the frame if `s_last`=1 or `fill`=NUM-1. Both conditions on the same beat close the frame once, not twice.
- Issue on the closing beat, all on the same edge:
  - `tree_din` ← fill buffer with the current beat merged in, and lanes above `fill` forced to 0.
  - `fill` ← 0.
  - The fill buffer is cleared to 0.
  - `{1, fill+1}` is pushed into the valid/count delay line.
- A new frame may start on the beat after the closing beat, so back-to-back frames run with no bubble.
- `tree_din` holds its last issued vector between issues. Only the delay line qualifies outputs.
- Delay line: TREE_LAT+1 stages of {valid, count}, shifted every cycle. When the tail is valid, `m_data` ← `tree_dout`, `m_count` ← tail count, and `m_valid` ← 1. Otherwise `m_valid` ← 0, and `m_data`/`m_count` hold their values.
- Arithmetic: the sum is the modulo-2^SIZE total of the real words; pad lanes contribute 0.
- Beats with `s_last`=1 are never dropped. An empty frame is impossible, because `s_last` always travels with a real word.

## Timing
- Reset values:
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `m_count`=0.
  - `tree_din` all 0, `fill`=0, fill buffer 0, delay line all invalid.
- Reset mid-frame discards the partial frame. Reset also clears the delay line, so sums already in flight never produce `m_valid`. On the first edge after `rst` falls, the block is in IDLE.
- Latency: a closing beat accepted on edge E drives `tree_din` from E. `m_valid` is high in the cycle following edge E+TREE_LAT+1. For NUM=4 that is E+3; for NUM=1024 it is E+11.
- NUM=1: every beat closes a frame. `m_count`=1, and `m_valid` rises at E+1.
- Throughput: one frame per NUM beats at full rate. `m_valid` pulses are never merged; each frame produces exactly one pulse.

## Test plan
- NUM=4, SIZE=8: stream 1,2,3,4 on 4 consecutive cycles with `s_last` on the 4th → one `m_valid` at E+3, `m_data`=10, `m_count`=4.
- NUM=4: 5,6 with `s_last` on the 2nd → `m_data`=11, `m_count`=2, and lanes 2–3 of `tree_din` = 0.
- NUM=4, back-to-back frames {255,1,0,0} and {7,7,7,7} with no gap → two pulses on consecutive cycles with `m_data`=0 (wrap) and then 28.
- NUM=4: `s_valid` toggling 1/0 across 8 beats, no `s_last` → two frames. Sums match, and `m_valid` comes exactly 3 edges after each closing beat.
- NUM=4: assert `rst` one cycle after accepting 2 words, and another while a closed frame is in flight → no `m_valid`. The next frame 1,1,1,1 yields exactly 4.
- NUM=1024, SIZE=10: 1024 beats of value 1 → `m_data`=0 (1024 mod 1024), `m_count`=1024, latency 11 edges.

Source files
------------

// File: rtl/adder_tree_feeder_if.sv
// Stream, tree and result signals of the adder tree feeder.
// slave is the feeder side; master is the side that drives words and the tree sum.
interface adder_tree_feeder_if #(
    parameter int SIZE = 10,
    parameter int NUM  = 1024
);
    localparam int CW = $clog2(NUM + 1);

    logic                      s_valid;
    logic                      s_ready;
    logic [SIZE-1:0]           s_data;
    logic                      s_last;
    logic [0:NUM-1][SIZE-1:0]  tree_din;
    logic [SIZE-1:0]           tree_dout;
    logic                      m_valid;
    logic [SIZE-1:0]           m_data;
    logic [CW-1:0]             m_count;

    modport slave (
        input  s_valid, s_data, s_last, tree_dout,
        output s_ready, tree_din, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, s_last, tree_dout,
        input  s_ready, tree_din, m_valid, m_data, m_count
    );
endinterface

// File: rtl/adder_tree_feeder.sv
// Packs up to NUM stream words into one zero-padded vector for the adder tree; sum out TREE_LAT+1 edges after the closing beat.
// Never backpressures: s_ready follows reset only, since the tree accepts a vector every cycle.
module adder_tree_feeder #(
    parameter int SIZE = 10,
    parameter int NUM  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    adder_tree_feeder_if.slave bus
);
    localparam int TREE_LAT = (NUM == 1) ? 0 : $clog2(NUM);
    localparam int CW       = $clog2(NUM + 1);
    localparam int FW       = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [FW-1:0] LAST_LANE = FW'(NUM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [FW-1:0]             r_fill;
    logic [0:NUM-1][SIZE-1:0]  r_buf;
    logic [0:NUM-1][SIZE-1:0]  r_tree_din;
    logic [0:NUM-1][SIZE-1:0]  w_merge;
    logic                      r_dv [0:TREE_LAT];
    logic [CW-1:0]             r_dc [0:TREE_LAT];
    logic                      r_m_valid;
    logic [SIZE-1:0]           r_m_data;
    logic [CW-1:0]             r_m_count;
    logic                      w_rdy;
    logic                      w_acc;
    logic                      w_close;
    logic [CW-1:0]             w_cnt;

    assign w_rdy   = ~rst;
    assign w_acc   = bus.s_valid & w_rdy;
    assign w_close = w_acc & (bus.s_last | (r_fill == LAST_LANE));
    assign w_cnt   = CW'(r_fill) + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc && !w_close) w_state_nxt = FILL;
            FILL:    if (w_close)           w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Issued vector: buffered lanes below fill, current word at fill, zero above.
    always_comb begin
        w_merge = '0;
        for (int i = 0; i < NUM; i++) begin
            if (FW'(i) == r_fill) begin
                w_merge[i] = bus.s_data;
            end else if (FW'(i) < r_fill) begin
                w_merge[i] = r_buf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill     <= '0;
            r_buf      <= '0;
            r_tree_din <= '0;
        end else if (w_acc) begin
            if (w_close) begin
                r_tree_din <= w_merge;
                r_fill     <= '0;
                r_buf      <= '0;
            end else begin
                r_buf[r_fill] <= bus.s_data;
                r_fill        <= r_fill + FW'(1);
            end
        end
    end

    // Valid/count travel alongside the tree so the tail lines up with tree_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= TREE_LAT; i++) begin
                r_dv[i] <= 1'b0;
                r_dc[i] <= '0;
            end
        end else begin
            r_dv[0] <= w_close;
            r_dc[0] <= w_cnt;
            for (int i = 1; i <= TREE_LAT; i++) begin
                r_dv[i] <= r_dv[i-1];
                r_dc[i] <= r_dc[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_count <= '0;
        end else if (r_dv[TREE_LAT]) begin
            r_m_valid <= 1'b1;
            r_m_data  <= bus.tree_dout;
            r_m_count <= r_dc[TREE_LAT];
        end else begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.s_ready  = w_rdy;
    assign bus.tree_din = r_tree_din;
    assign bus.m_valid  = r_m_valid;
    assign bus.m_data   = r_m_data;
    assign bus.m_count  = r_m_count;
endmodule
